keypad_time_entry: RTL and testbench

//  Input-side counterpart of the 7-segment display driver. Scans a 4x4 matrix keypad, debounces it and emits one event per press.

---
 rtl/keypad_time_entry.sv | 345 ++++++++++++++++++++++++++++++++++
 tb/tb_keypad_time_entry.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_time_entry.sv
// keypad_time_entry
//    Scans a 4x4 active-low matrix keypad, debounces it into one event per
//    press, and assembles six typed digits into a packed time word
//    {hh[20:14], mm[13:7], ss[6:0]} (7-bit binary fields) for the clock core.
//
// Ports
//    clk          system clock
//    rst          synchronous active-low reset
//    row[3:0]     keypad rows, active-low, asynchronous to clk
//    col[3:0]     keypad column drive, active-low one-hot
//    key_valid    one-cycle pulse per debounced press
//    key_code     code of the last press (0-9, A=10, B=11, C=12, D=13, *=14, #=15)
//    edit_active  high while in entry mode
//    edit_pos     number of digits entered so far, 0..6
//    edit_data    packed time built from the entered digits
//    entry_err    one-cycle pulse when a key is rejected
//    time_out     last committed time {hh, mm, ss}
//    time_load    one-cycle pulse when time_out is updated
module keypad_time_entry #(
   parameter logic [15:0] SCAN_DIV   = 16'd49_999,
   parameter logic [3:0]  DEB_PASSES = 4'd5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  row,
   output logic [3:0]  col,
   output logic        key_valid,
   output logic [3:0]  key_code,
   output logic        edit_active,
   output logic [2:0]  edit_pos,
   output logic [20:0] edit_data,
   output logic        entry_err,
   output logic [20:0] time_out,
   output logic        time_load
);

   localparam logic [3:0] KEY_A     = 4'd10;
   localparam logic [3:0] KEY_B     = 4'd11;
   localparam logic [3:0] KEY_STAR  = 4'd14;
   localparam logic [3:0] KEY_HASH  = 4'd15;

   typedef enum logic [1:0] {
      DEB_RELEASED,
      DEB_PRESS_CHK,
      DEB_PRESSED,
      DEB_RELEASE_CHK
   } debState_t;

   typedef enum logic {
      ENT_IDLE,
      ENT_EDIT
   } entState_t;

   logic [3:0]  rowMeta_q, rowSync_q;
   logic [15:0] divCnt_q;
   logic [1:0]  colIdx_q;
   logic [3:0]  col_q;
   logic [15:0] passMask_q;

   logic        slotEnd, passEnd;
   logic [15:0] slotMask;
   logic [4:0]  closedCount;
   logic [3:0]  closedIdx;
   logic        passNone, passKey;
   logic [3:0]  passCode;

   debState_t   debState_q, debState_d;
   logic [3:0]  debCnt_q, debCnt_d;
   logic [3:0]  cand_q, cand_d;
   logic        keyValid_q, keyValid_d;
   logic [3:0]  keyCode_q, keyCode_d;
   logic [3:0]  debCntInc;

   entState_t   entState_q, entState_d;
   logic [2:0]  editPos_q, editPos_d;
   logic [23:0] digits_q, digits_d;
   logic        entryErr_q, entryErr_d;
   logic [20:0] timeOut_q, timeOut_d;
   logic        timeLoad_q, timeLoad_d;
   logic        digitOk;
   logic [2:0]  editPosDec;
   logic [20:0] editData;

   // Translates a switch position {row, col} into the code printed on the key.
   function automatic logic [3:0] keyMap(input logic [3:0] idx);
      logic [3:0] code;
      case (idx)
         4'd0:    code = 4'd1;
         4'd1:    code = 4'd2;
         4'd2:    code = 4'd3;
         4'd3:    code = 4'd10;
         4'd4:    code = 4'd4;
         4'd5:    code = 4'd5;
         4'd6:    code = 4'd6;
         4'd7:    code = 4'd11;
         4'd8:    code = 4'd7;
         4'd9:    code = 4'd8;
         4'd10:   code = 4'd9;
         4'd11:   code = 4'd12;
         4'd12:   code = 4'd14;
         4'd13:   code = 4'd0;
         4'd14:   code = 4'd15;
         default: code = 4'd13;
      endcase
      return code;
   endfunction

   // Two decimal digits to one 7-bit binary field; the entry limits keep it <= 99.
   function automatic logic [6:0] packField(input logic [3:0] tens, input logic [3:0] units);
      return ({3'b000, tens} * 7'd10) + {3'b000, units};
   endfunction

   // The divider sets how long each column is driven. A slot ends when it hits
   // SCAN_DIV; the last slot of column 3 also closes the pass.
   assign slotEnd = (divCnt_q == SCAN_DIV);
   assign passEnd = slotEnd && (colIdx_q == 2'd3);

   // Merges the current column's closed switches into the pass accumulator,
   // then counts them so the pass can be classified as none, one key or several.
   always_comb begin
      slotMask    = passMask_q;
      closedCount = 5'd0;
      closedIdx   = 4'd0;
      for (int r = 0; r < 4; r++) begin
         if (!rowSync_q[r]) begin
            slotMask[{r[1:0], colIdx_q}] = 1'b1;
         end
      end
      for (int i = 0; i < 16; i++) begin
         if (slotMask[i]) begin
            closedCount = closedCount + 5'd1;
            closedIdx   = 4'(i);
         end
      end
   end

   assign passNone = (closedCount == 5'd0);
   assign passKey  = (closedCount == 5'd1);
   assign passCode = keyMap(closedIdx);

   // Rows are asynchronous, so they cross a 2-flop synchronizer first. The
   // column drive is registered from the index, so it lags the index by a cycle;
   // the synchronizer delay still leaves the sampled row settled for that column.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rowMeta_q  <= 4'hF;
         rowSync_q  <= 4'hF;
         divCnt_q   <= 16'd0;
         colIdx_q   <= 2'd0;
         col_q      <= 4'hF;
         passMask_q <= 16'd0;
      end else begin
         rowMeta_q <= row;
         rowSync_q <= rowMeta_q;
         col_q     <= ~(4'b0001 << colIdx_q);
         if (slotEnd) begin
            divCnt_q   <= 16'd0;
            colIdx_q   <= colIdx_q + 2'd1;
            passMask_q <= passEnd ? 16'd0 : slotMask;
         end else begin
            divCnt_q <= divCnt_q + 16'd1;
         end
      end
   end

   assign debCntInc = debCnt_q + 4'd1;

   // Debounce decisions are taken only at pass boundaries. A press must be seen
   // as the same single key for DEB_PASSES passes, and a release as empty passes
   // for the same count; anything else falls back to the previous stable state.
   always_comb begin
      debState_d = debState_q;
      debCnt_d   = debCnt_q;
      cand_d     = cand_q;
      keyValid_d = 1'b0;
      keyCode_d  = keyCode_q;
      if (passEnd) begin
         case (debState_q)
            DEB_RELEASED: begin
               if (passKey) begin
                  debState_d = DEB_PRESS_CHK;
                  cand_d     = passCode;
                  debCnt_d   = 4'd1;
               end
            end
            DEB_PRESS_CHK: begin
               if (passKey && (passCode == cand_q)) begin
                  debCnt_d = debCntInc;
                  if (debCntInc >= DEB_PASSES) begin
                     keyValid_d = 1'b1;
                     keyCode_d  = cand_q;
                     debState_d = DEB_PRESSED;
                  end
               end else begin
                  debState_d = DEB_RELEASED;
               end
            end
            DEB_PRESSED: begin
               if (passNone) begin
                  debState_d = DEB_RELEASE_CHK;
                  debCnt_d   = 4'd1;
               end
            end
            DEB_RELEASE_CHK: begin
               if (passNone) begin
                  debCnt_d = debCntInc;
                  if (debCntInc >= DEB_PASSES) begin
                     debState_d = DEB_RELEASED;
                  end
               end else begin
                  debState_d = DEB_PRESSED;
               end
            end
            default: debState_d = DEB_RELEASED;
         endcase
      end
   end

   // Debounce state register; key_code is kept until the next accepted press.
   always_ff @(posedge clk) begin
      if (!rst) begin
         debState_q <= DEB_RELEASED;
         debCnt_q   <= 4'd0;
         cand_q     <= 4'd0;
         keyValid_q <= 1'b0;
         keyCode_q  <= 4'd0;
      end else begin
         debState_q <= debState_d;
         debCnt_q   <= debCnt_d;
         cand_q     <= cand_d;
         keyValid_q <= keyValid_d;
         keyCode_q  <= keyCode_d;
      end
   end

   // Per-position digit limits keep every packed field a legal time value.
   // Hours units depend on the hours tens already stored (20-23 only).
   always_comb begin
      digitOk = 1'b0;
      if (keyCode_q <= 4'd9) begin
         case (editPos_q)
            3'd0:    digitOk = (keyCode_q <= 4'd2);
            3'd1:    digitOk = (digits_q[3:0] == 4'd2) ? (keyCode_q <= 4'd3) : 1'b1;
            3'd2:    digitOk = (keyCode_q <= 4'd5);
            3'd3:    digitOk = 1'b1;
            3'd4:    digitOk = (keyCode_q <= 4'd5);
            3'd5:    digitOk = 1'b1;
            default: digitOk = 1'b0;
         endcase
      end
   end

   assign editPosDec = editPos_q - 3'd1;

   assign editData = {packField(digits_q[3:0],   digits_q[7:4]),
                      packField(digits_q[11:8],  digits_q[15:12]),
                      packField(digits_q[19:16], digits_q[23:20])};

   // Entry mode: A opens an edit, digits fill positions 0..5, B deletes the
   // last digit, * abandons the edit and # commits a complete entry. Digits are
   // stored one nibble per position, position 0 in the lowest nibble.
   always_comb begin
      entState_d = entState_q;
      editPos_d  = editPos_q;
      digits_d   = digits_q;
      entryErr_d = 1'b0;
      timeOut_d  = timeOut_q;
      timeLoad_d = 1'b0;
      if (keyValid_q) begin
         case (entState_q)
            ENT_IDLE: begin
               if (keyCode_q == KEY_A) begin
                  entState_d = ENT_EDIT;
                  editPos_d  = 3'd0;
                  digits_d   = 24'd0;
               end
            end
            ENT_EDIT: begin
               if (keyCode_q <= 4'd9) begin
                  if (digitOk) begin
                     digits_d[{editPos_q, 2'b00} +: 4] = keyCode_q;
                     editPos_d = editPos_q + 3'd1;
                  end else begin
                     entryErr_d = 1'b1;
                  end
               end else begin
                  case (keyCode_q)
                     KEY_B: begin
                        if (editPos_q != 3'd0) begin
                           editPos_d = editPosDec;
                           digits_d[{editPosDec, 2'b00} +: 4] = 4'd0;
                        end else begin
                           entryErr_d = 1'b1;
                        end
                     end
                     KEY_STAR: entState_d = ENT_IDLE;
                     KEY_HASH: begin
                        if (editPos_q == 3'd6) begin
                           timeOut_d  = editData;
                           timeLoad_d = 1'b1;
                           entState_d = ENT_IDLE;
                        end else begin
                           entryErr_d = 1'b1;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            default: entState_d = ENT_IDLE;
         endcase
      end
   end

   // Entry state register; everything here returns to zero on reset,
   // including the last committed time.
   always_ff @(posedge clk) begin
      if (!rst) begin
         entState_q <= ENT_IDLE;
         editPos_q  <= 3'd0;
         digits_q   <= 24'd0;
         entryErr_q <= 1'b0;
         timeOut_q  <= 21'd0;
         timeLoad_q <= 1'b0;
      end else begin
         entState_q <= entState_d;
         editPos_q  <= editPos_d;
         digits_q   <= digits_d;
         entryErr_q <= entryErr_d;
         timeOut_q  <= timeOut_d;
         timeLoad_q <= timeLoad_d;
      end
   end

   assign col         = col_q;
   assign key_valid   = keyValid_q;
   assign key_code    = keyCode_q;
   assign edit_active = (entState_q == ENT_EDIT);
   assign edit_pos    = editPos_q;
   assign edit_data   = editData;
   assign entry_err   = entryErr_q;
   assign time_out    = timeOut_q;
   assign time_load   = timeLoad_q;

endmodule

// File: tb/tb_keypad_time_entry.sv
// tb_keypad_time_entry
//    Directed bench for keypad_time_entry with a fast scan (4 cycles per
//    column, 16 per pass) and 2-pass debounce. A small keypad model closes
//    switches in pressedMask (bit = row*4 + col) onto the row lines.
module tb_keypad_time_entry;

   logic        clk;
   logic        rst;
   logic [3:0]  row;
   logic [3:0]  col;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        edit_active;
   logic [2:0]  edit_pos;
   logic [20:0] edit_data;
   logic        entry_err;
   logic [20:0] time_out;
   logic        time_load;

   logic [15:0] pressedMask;
   int          checkCount;
   int          failCount;
   int          validCnt;
   int          errCnt;
   int          loadCnt;

   keypad_time_entry #(
      .SCAN_DIV   (16'd3),
      .DEB_PASSES (4'd2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .row         (row),
      .col         (col),
      .key_valid   (key_valid),
      .key_code    (key_code),
      .edit_active (edit_active),
      .edit_pos    (edit_pos),
      .edit_data   (edit_data),
      .entry_err   (entry_err),
      .time_out    (time_out),
      .time_load   (time_load)
   );

   // 100 MHz-style free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Keypad model: a closed switch pulls its row low while its column is driven.
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (pressedMask[r*4 + c] && !col[c]) row[r] = 1'b0;
         end
      end
   end

   // Pulse counters sampled on the falling edge, away from the active edge.
   initial begin
      validCnt = 0;
      errCnt   = 0;
      loadCnt  = 0;
   end
   always @(negedge clk) begin
      if (key_valid) validCnt++;
      if (entry_err) errCnt++;
      if (time_load) loadCnt++;
   end

   // Keeps a broken design from hanging the run.
   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Switch position of each key code on the physical keypad.
   function automatic logic [15:0] keyBit(input int code);
      int pos;
      case (code)
         1: pos = 0;   2: pos = 1;   3: pos = 2;   10: pos = 3;
         4: pos = 4;   5: pos = 5;   6: pos = 6;   11: pos = 7;
         7: pos = 8;   8: pos = 9;   9: pos = 10;  12: pos = 11;
         14: pos = 12; 0: pos = 13;  15: pos = 14; default: pos = 15;
      endcase
      return 16'd1 << pos;
   endfunction

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Holds a switch pattern for holdPasses passes, then releases for relPasses.
   task automatic applyStimulus(input logic [15:0] mask, input int holdPasses, input int relPasses);
      pressedMask = mask;
      waitCycles(16 * holdPasses);
      pressedMask = 16'd0;
      waitCycles(16 * relPasses);
   endtask

   task automatic pressKey(input int code);
      applyStimulus(keyBit(code), 3, 4);
   endtask

   task automatic checkResetState();
      checkOutput("rst_col",         32'(col),         32'hF);
      checkOutput("rst_key_valid",   32'(key_valid),   32'd0);
      checkOutput("rst_key_code",    32'(key_code),    32'd0);
      checkOutput("rst_edit_active", 32'(edit_active), 32'd0);
      checkOutput("rst_edit_pos",    32'(edit_pos),    32'd0);
      checkOutput("rst_edit_data",   32'(edit_data),   32'd0);
      checkOutput("rst_entry_err",   32'(entry_err),   32'd0);
      checkOutput("rst_time_out",    32'(time_out),    32'd0);
      checkOutput("rst_time_load",   32'(time_load),   32'd0);
   endtask

   initial begin
      int          seq [7];
      int          v0;
      int          e0;
      int          l0;
      logic [3:0]  expCol;
      logic [20:0] expTime;

      seq         = '{10, 1, 2, 3, 4, 5, 6};
      expTime     = {7'd12, 7'd34, 7'd56};
      checkCount  = 0;
      failCount   = 0;
      pressedMask = 16'd0;
      rst         = 1'b0;

      // Reset for two edges, then watch the column walk.
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkResetState();
      rst = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         expCol = ~(4'b0001 << (((k - 1) / 4) % 4));
         checkOutput("col_scan", 32'(col), 32'(expCol));
      end

      // Debounced single press of 5, short hold.
      v0 = validCnt;
      applyStimulus(keyBit(5), 3, 4);
      checkOutput("press5_pulses", validCnt - v0, 32'd1);
      checkOutput("press5_code",   32'(key_code), 32'd5);

      // Long hold: no auto-repeat.
      v0 = validCnt;
      applyStimulus(keyBit(5), 10, 4);
      checkOutput("long_hold_pulses", validCnt - v0, 32'd1);

      // Bounce-length press of 8 is rejected; key_code keeps the old value.
      v0 = validCnt;
      applyStimulus(keyBit(8), 1, 4);
      checkOutput("short_press_pulses", validCnt - v0, 32'd0);
      checkOutput("short_press_code",   32'(key_code), 32'd5);

      // Two keys at once never qualify.
      v0 = validCnt;
      applyStimulus(keyBit(1) | keyBit(2), 3, 4);
      checkOutput("multi_pulses", validCnt - v0, 32'd0);

      // Full entry of 12:34:56 and commit.
      for (int i = 0; i < 7; i++) begin
         pressKey(seq[i]);
         checkOutput("entry_pos", 32'(edit_pos), 32'(i));
         checkOutput("entry_active", 32'(edit_active), 32'd1);
      end
      checkOutput("entry_data", 32'(edit_data), 32'(expTime));
      l0 = loadCnt;
      pressKey(15);
      checkOutput("commit_loads",  loadCnt - l0, 32'd1);
      checkOutput("commit_time",   32'(time_out), 32'(expTime));
      checkOutput("commit_active", 32'(edit_active), 32'd0);

      // Limit violations, early commit, backspace and abort.
      e0 = errCnt;
      pressKey(10);
      pressKey(2);
      pressKey(4);
      checkOutput("htens2_err", errCnt - e0, 32'd1);
      checkOutput("htens2_pos", 32'(edit_pos), 32'd1);
      pressKey(3);
      checkOutput("hunits3_pos", 32'(edit_pos), 32'd2);
      pressKey(7);
      checkOutput("mtens_err", errCnt - e0, 32'd2);
      checkOutput("mtens_pos", 32'(edit_pos), 32'd2);
      pressKey(15);
      checkOutput("early_hash_err", errCnt - e0, 32'd3);
      checkOutput("early_hash_pos", 32'(edit_pos), 32'd2);
      pressKey(11);
      checkOutput("backspace_pos",  32'(edit_pos), 32'd1);
      checkOutput("backspace_data", 32'(edit_data), 32'({7'd20, 14'd0}));
      pressKey(14);
      checkOutput("abort_active", 32'(edit_active), 32'd0);
      checkOutput("abort_time",   32'(time_out), 32'(expTime));
      checkOutput("abort_loads",  loadCnt - l0, 32'd1);

      // Reset in the middle of an entry clears everything, time_out included.
      pressKey(10);
      pressKey(1);
      pressKey(2);
      pressKey(3);
      checkOutput("midentry_pos", 32'(edit_pos), 32'd3);
      rst = 1'b0;
      waitCycles(2);
      checkResetState();
      rst = 1'b1;
      waitCycles(2);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
